// File: rtl/line_clear.sv
// Full-board line-clear sequencer: scans rows bottom-up, shifts everything above
// a full row down by one, blanks the top row, and rescans the same row.
//
// state     | meaning
// IDLE      | waiting for start
// SCAN      | issuing reads for row y, x = 0..W-1
// EVAL      | last cell of row y returns; decide full / not full
// SHIFT_RD  | read cell (r-1, x)
// SHIFT_WR  | write that cell into (r, x)
// CLEAR_TOP | write zeros across row 0
// DONE      | one-cycle completion pulse
module line_clear #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 25
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [5:0] ram_Q,
  output logic [7:0] ram_addr,
  output logic [5:0] ram_data,
  output logic       ram_wren,
  output logic       busy,
  output logic       done,
  output logic [2:0] lines_cleared
);

  localparam int XW = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
  localparam int YW = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(BOARD_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(BOARD_H - 1);
  localparam logic [7:0]    W8     = 8'(BOARD_W);

  typedef enum logic [2:0] {
    IDLE, SCAN, EVAL, SHIFT_RD, SHIFT_WR, CLEAR_TOP, DONE
  } state_t;

  state_t        state, state_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [YW-1:0] r, r_n;
  logic          full, full_n;
  logic [2:0]    lines_n;
  logic          row_full;

  function automatic logic [7:0] cell_addr(input logic [YW-1:0] row,
                                           input logic [XW-1:0] col);
    return 8'(row) * W8 + 8'(col);
  endfunction

  // The last cell's read data only arrives in EVAL, so fold it in here.
  assign row_full = full && (ram_Q != 6'd0);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      r             <= '0;
      full          <= 1'b0;
      lines_cleared <= 3'd0;
    end else begin
      state         <= state_n;
      x             <= x_n;
      y             <= y_n;
      r             <= r_n;
      full          <= full_n;
      lines_cleared <= lines_n;
    end
  end

  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    r_n      = r;
    full_n   = full;
    lines_n  = lines_cleared;
    ram_addr = 8'd0;
    ram_data = 6'd0;
    ram_wren = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SCAN;
          y_n     = Y_LAST;
          x_n     = '0;
          full_n  = 1'b1;
          lines_n = 3'd0;
        end
      end
      SCAN: begin
        ram_addr = cell_addr(y, x);
        // At x=0 ram_Q still belongs to whatever was addressed before the row.
        if (x != '0 && ram_Q == 6'd0) full_n = 1'b0;
        if (x == X_LAST) begin
          x_n     = '0;
          state_n = EVAL;
        end else begin
          x_n = x + XW'(1);
        end
      end
      EVAL: begin
        if (!row_full) begin
          if (y == '0) begin
            state_n = DONE;
          end else begin
            y_n     = y - YW'(1);
            x_n     = '0;
            full_n  = 1'b1;
            state_n = SCAN;
          end
        end else begin
          lines_n = (lines_cleared == 3'd7) ? 3'd7 : lines_cleared + 3'd1;
          r_n     = y;
          x_n     = '0;
          state_n = (y == '0) ? CLEAR_TOP : SHIFT_RD;
        end
      end
      SHIFT_RD: begin
        ram_addr = cell_addr(r - YW'(1), x);
        state_n  = SHIFT_WR;
      end
      SHIFT_WR: begin
        ram_addr = cell_addr(r, x);
        ram_data = ram_Q;
        ram_wren = 1'b1;
        if (x == X_LAST) begin
          x_n     = '0;
          r_n     = r - YW'(1);
          state_n = (r == YW'(1)) ? CLEAR_TOP : SHIFT_RD;
        end else begin
          x_n     = x + XW'(1);
          state_n = SHIFT_RD;
        end
      end
      CLEAR_TOP: begin
        ram_addr = cell_addr('0, x);
        ram_wren = 1'b1;
        if (x == X_LAST) begin
          x_n     = '0;
          full_n  = 1'b1;
          state_n = SCAN;
        end else begin
          x_n = x + XW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/line_clear.md
LINE_CLEAR -- requirements
Module: line_clear

Interface
REQ-001 SHALL have parameter BOARD_W, default 10, board columns.
REQ-002 SHALL have parameter BOARD_H, default 25, board rows; row 0 is the top row.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-004 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request a full-board line-clear pass.
REQ-006 SHALL have port ram_Q, input, 6, board RAM read data; 6'b000000 means an empty cell.
REQ-007 SHALL have port ram_addr, output, 8, board RAM address = y*BOARD_W + x (row-major).
REQ-008 SHALL have port ram_data, output, 6, board RAM write data.
REQ-009 SHALL have port ram_wren, output, 1, board RAM write enable.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at the end of a pass.
REQ-012 SHALL have port lines_cleared, output, 3, rows removed in the last pass; holds until the next start.

Function
REQ-013 SHALL treat the RAM as synchronous read: ram_Q reflects the ram_addr presented one cycle earlier.
REQ-014 SHALL implement states IDLE, SCAN, EVAL, SHIFT_RD, SHIFT_WR, CLEAR_TOP, DONE.
REQ-015 IDLE: start=1 -> SCAN with y=BOARD_H-1, x=0, full flag=1, lines_cleared=0; start is ignored in every other state.
REQ-016 SCAN: present address (y,x) for x=0..BOARD_W-1, one per cycle (10 cycles), then -> EVAL.
REQ-017 Full flag SHALL clear on any returned ram_Q==0 for the current row; the final cell's data is sampled in EVAL.
REQ-018 EVAL, row not full: if y==0 -> DONE, else y<=y-1, x=0, full flag=1 -> SCAN.
REQ-019 EVAL, row full: lines_cleared<=lines_cleared+1, saturating at 7; set r=y, x=0; if y==0 -> CLEAR_TOP, else -> SHIFT_RD.
REQ-020 SHIFT_RD: present address (r-1,x), ram_wren=0 -> SHIFT_WR.
REQ-021 SHIFT_WR: ram_addr=(r,x), ram_data=ram_Q, ram_wren=1; next x, or at x=BOARD_W-1 set x=0 and r<=r-1; -> CLEAR_TOP when r reaches 0, else -> SHIFT_RD.
REQ-022 CLEAR_TOP: write 0 to (0,x) for x=0..BOARD_W-1, one per cycle with ram_wren=1; then rescan the same y (no decrement), full flag=1, -> SCAN.
REQ-023 Rescanning the same y after a clear SHALL make consecutive full rows (up to 4 and beyond) clear correctly.
REQ-024 DONE: done=1 for exactly one cycle -> IDLE.
REQ-025 ram_wren SHALL be 1 only in SHIFT_WR and CLEAR_TOP.
REQ-026 Cycle cost: 11 cycles per scanned row, 20 cycles per shifted row, 10 for CLEAR_TOP, 1 for DONE.
REQ-027 Address arithmetic SHALL be 8 bits wide with no overflow for BOARD_W*BOARD_H<=256.

Reset
REQ-028 resetn=0 at any posedge SHALL force IDLE, ram_wren=0, done=0, busy=0, lines_cleared=0, ram_addr=0, ram_data=0, x=0, y=0, r=0.
REQ-029 Reset during SHIFT_WR or CLEAR_TOP SHALL abort the pass with no further writes; a partially shifted board is acceptable.

Verification
REQ-030 Empty board, start pulse -> no ram_wren ever; done high exactly 276 cycles after the start edge; lines_cleared=0.
REQ-031 Row 24 full (colour 6'h05), row 23 cell x=3 = 6'h0C, rest empty -> after done: row 24 holds 6'h0C only at x=3, row 0 all zero, lines_cleared=1.
REQ-032 Rows 21-24 full, row 20 x=0 = 6'h11 -> lines_cleared=4; row 24 x=0 = 6'h11; rows 0-23 empty.
REQ-033 Row 0 only full -> CLEAR_TOP entered directly with no SHIFT states; row 0 zeroed; lines_cleared=1.
REQ-034 resetn=0 asserted for one cycle mid-SHIFT_WR -> next cycle ram_wren=0, busy=0; a subsequent start runs a clean pass.
REQ-035 start held high through an entire pass -> exactly one done pulse per IDLE->SCAN entry, and no start sampled while busy=1.
